// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program loader.
// Holds the receiver state encoding, the default end-of-program marker, and
// the UART frame shape (8 data bits, 1 stop bit) plus the word packing factor.
package uart_prog_loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam logic [31:0] END_WORD_DEFAULT = 32'h0000_0FFF;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_STOP_BITS = 1;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver with a 2-flop input synchronizer.
// Ports:
//   wb_clk_i, wb_rst_i  clock, async active-high reset
//   en_i                receive enable; low forces IDLE and drops any partial byte
//   rx_i                asynchronous serial line, idle high
//   data_o              received byte (valid while byte_valid_c_o is high)
//   byte_valid_c_o      one-cycle pulse in the stop-bit sample cycle, stop bit good
//   frame_err_c_o       one-cycle pulse in the stop-bit sample cycle, stop bit low
//   busy_o              high while in START, DATA or STOP
module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       en_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       byte_valid_c_o,
    output logic       frame_err_c_o,
    output logic       busy_o
);

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned BIT_IDX_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]     STOP_LAST = CNT_W'(CLKS_PER_BIT * UART_STOP_BITS - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(UART_DATA_BITS - 1);

    logic [1:0]           sync_q;
    logic                 rx_prev_q;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0] bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 busy_q;

    logic rx_s;
    logic fall_edge;

    assign rx_s      = sync_q[1];
    assign fall_edge = rx_prev_q & ~rx_s;

    // Synchronizer and edge-detect history; idle-high reset avoids a false start.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rx_i};
            rx_prev_q <= rx_s;
        end
    end

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            busy_q  <= (state_d != RX_IDLE);
        end
    end

    // Next-state and strobe logic; the counter free-runs and is cleared at each sample point.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q + CNT_W'(1);
        bit_d          = bit_q;
        shift_d        = shift_q;
        byte_valid_c_o = 1'b0;
        frame_err_c_o  = 1'b0;

        if (!en_i) begin
            state_d = RX_IDLE;
            cnt_d   = '0;
            bit_d   = '0;
        end else begin
            unique case (state_q)
                RX_IDLE: begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (fall_edge) begin
                        state_d = RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_d   = '0;
                        state_d = rx_s ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[7:1]};
                        if (bit_q == LAST_BIT) begin
                            state_d = RX_STOP;
                        end else begin
                            bit_d = bit_q + BIT_IDX_W'(1);
                        end
                    end
                end
                RX_STOP: begin
                    if (cnt_q == STOP_LAST) begin
                        cnt_d          = '0;
                        state_d        = RX_IDLE;
                        byte_valid_c_o = rx_s;
                        frame_err_c_o  = ~rx_s;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    assign data_o = shift_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: packs received bytes little-endian into 32-bit words
// and writes them to consecutive program-memory addresses until END_WORD.
// Ports:
//   wb_clk_i, wb_rst_i  clock, async active-high reset
//   en_i                loader enable
//   rx_i                UART serial line (8N1, LSB first, idle high)
//   we_o                one-cycle write strobe
//   addr_o              word address of the write
//   wdata_o             write data
//   busy_o              frame reception in progress
//   done_o              sticky, END_WORD received
//   frame_err_o         sticky, a stop-bit error was seen
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_W       = 10,
    parameter logic [31:0] END_WORD     = END_WORD_DEFAULT
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              en_i,
    input  logic              rx_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              frame_err_o
);

    localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [7:0]  rx_byte;
    logic        byte_valid_c;
    logic        byte_err_c;
    logic        rx_en;

    logic [31:0]       word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] acnt_q, acnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic [31:0]       full_word;

    // Once done, the receiver is held idle so line activity is ignored until reset.
    assign rx_en = en_i & ~done_q;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .en_i           (rx_en),
        .rx_i           (rx_i),
        .data_o         (rx_byte),
        .byte_valid_c_o (byte_valid_c),
        .frame_err_c_o  (byte_err_c),
        .busy_o         (busy_o)
    );

    assign full_word = {rx_byte, word_q[23:0]};

    // Word assembly, write generation and end-marker detection.
    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        acnt_d  = acnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        ferr_d  = ferr_q | byte_err_c;

        if (byte_valid_c) begin
            if (idx_q == LAST_IDX) begin
                idx_d = '0;
                if (full_word == END_WORD) begin
                    done_d = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = acnt_q;
                    wdata_d = full_word;
                    acnt_d  = acnt_q + ADDR_W'(1);
                end
            end else begin
                word_d[{idx_q, 3'b000} +: 8] = rx_byte;
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            word_q  <= '0;
            idx_q   <= '0;
            acnt_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            acnt_q  <= acnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign we_o        = we_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign done_o      = done_q;
    assign frame_err_o = ferr_q;

endmodule
